ram_seq_ctrl: RTL
=================

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

Interface
REQ-001 Parameter bW, 14: data bitwidth, shared with the RAM.
REQ-002 Parameter eC, 784: RAM entry count; SHALL be a multiple of 4.
REQ-003 Parameter aW, 10: address width; 2^aW SHALL be at least eC.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1: reset, asynchronous, active-low.
REQ-006 Port start  in  1: begin one load-then-read frame; sampled only in IDLE.
REQ-007 Port in_valid  in  1: upstream write data valid.
REQ-008 Port in_data  in  bW: upstream write data.
REQ-009 Port in_ready  out  1: controller accepts in_data.
REQ-010 Port ram_wrEn  out  1: RAM write enable.
REQ-011 Port ram_wrAddr  out  aW: RAM write address.
REQ-012 Port ram_wrData  out  bW: RAM write data.
REQ-013 Port ram_rdAddr  out  aW: RAM base read address; RAM returns entries base..base+3 combinationally.
REQ-014 Port ram_rd1..ram_rd4  in  bW each: RAM read data, entries base+0..base+3.
REQ-015 Port out_valid  out  1: out_d1..out_d4 hold a valid group.
REQ-016 Port out_ready  in  1: downstream accepts the group.
REQ-017 Port out_d1..out_d4  out  bW each: registered group of 4 entries.
REQ-018 Port out_last  out  1: the current group is the final group of the frame.
REQ-019 Port busy  out  1: high in any state except IDLE.
REQ-020 Port done  out  1: one-cycle pulse at frame completion.

Function
REQ-021 The FSM SHALL have four states: IDLE, LOAD, READ, DONE.
REQ-022 IDLE: in_ready=0, ram_wrEn=0; start=1 -> LOAD with wcnt=0; start is ignored in all other states.
REQ-023 LOAD: in_ready=1; ram_wrEn = in_valid (combinational), ram_wrAddr=wcnt, ram_wrData=in_data; each accepted beat increments wcnt.
REQ-024 LOAD exit: the beat accepted with wcnt=eC-1 SHALL move the FSM to READ with rcnt=0; wcnt SHALL NOT wrap or exceed eC-1.
REQ-025 READ: ram_rdAddr=rcnt; the output register SHALL load {ram_rd1..ram_rd4} when it is empty (out_valid=0) or is being drained (out_valid & out_ready) and groups remain to issue; each load sets out_valid=1 and advances rcnt by 4.
REQ-026 READ throughput: with out_ready held high, one group per cycle; the first out_valid asserts in the cycle after READ entry.
REQ-027 out_last=1 exactly for the group loaded from base eC-4; rcnt SHALL NOT issue past eC-4.
REQ-028 Stall: while out_valid=1 and out_ready=0, out_d1..4, out_last and rcnt SHALL hold stable.
REQ-029 When the group with out_last=1 is accepted, out_valid SHALL clear and the FSM SHALL move to DONE.
REQ-030 DONE: done=1 for exactly one cycle, then IDLE; in_ready=0 and ram_wrEn=0 in READ and DONE.
REQ-031 Outside LOAD, ram_wrEn=0 regardless of in_valid; in_valid with in_ready=0 SHALL cause no write.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, wcnt=0, rcnt=0, out_valid=0, out_last=0, out_d1..4=0, done=0, busy=0, in_ready=0, ram_wrEn=0, ram_wrAddr=0, ram_rdAddr=0.
REQ-033 Reset asserted mid-LOAD or mid-READ SHALL abort the frame with no done pulse; after release, the next frame requires a new start.

Verification
REQ-034 Full frame: start, then eC beats of value = index with in_valid and out_ready held high -> writes to addresses 0..783; group k = {4k, 4k+1, 4k+2, 4k+3}; 196 groups; out_last on group 195; done one cycle later.
REQ-035 Gapped input: in_valid toggling 1/0 -> exactly 784 ram_wrEn pulses, addresses contiguous, no duplicates.
REQ-036 Backpressure: out_ready low for 5 cycles on group 10 -> out_d1..4 = {40,41,42,43} held stable; rcnt unchanged; no group lost or duplicated.
REQ-037 start pulsed during LOAD and READ -> ignored; frame completes normally with a single done pulse.
REQ-038 rst asserted after write 300 -> outputs at reset values immediately; no done; a new start reloads from address 0.
REQ-039 eC=8 variant: 8 writes -> 2 groups, out_last on the second, done pulse follows.

Source files
------------

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: fills an external RAM with eC words, then
// streams them back as registered groups of four entries.
module ram_seq_ctrl #(
  parameter int bW = 14,
  parameter int eC = 784,
  parameter int aW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [bW-1:0] in_data,
  output logic          in_ready,
  output logic          ram_wrEn,
  output logic [aW-1:0] ram_wrAddr,
  output logic [bW-1:0] ram_wrData,
  output logic [aW-1:0] ram_rdAddr,
  input  logic [bW-1:0] ram_rd1,
  input  logic [bW-1:0] ram_rd2,
  input  logic [bW-1:0] ram_rd3,
  input  logic [bW-1:0] ram_rd4,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [bW-1:0] out_d1,
  output logic [bW-1:0] out_d2,
  output logic [bW-1:0] out_d3,
  output logic [bW-1:0] out_d4,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE, LOAD, READ, DONE
  } state_t;

  localparam logic [aW-1:0] WLAST = aW'(eC - 1);
  localparam logic [aW-1:0] RLAST = aW'(eC - 4);

  state_t        state, state_nx;
  logic [aW-1:0] wcnt, rcnt;
  logic          rd_end;
  logic          wr_fire, rd_load, rd_take;

  assign ram_wrAddr = wcnt;
  assign ram_wrData = in_data;
  assign ram_rdAddr = rcnt;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    ram_wrEn = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    wr_fire  = 1'b0;
    rd_load  = 1'b0;
    rd_take  = out_valid & out_ready;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        ram_wrEn = in_valid;
        wr_fire  = in_valid;
        if (in_valid && wcnt == WLAST)
          state_nx = READ;
      end
      READ: begin
        rd_load = !rd_end && (!out_valid || out_ready);
        if (rd_take && out_last)
          state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // wcnt saturates at the last address instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
    end else if (state == IDLE && start) begin
      wcnt <= '0;
    end else if (wr_fire && wcnt != WLAST) begin
      wcnt <= wcnt + aW'(1);
    end
  end

  // rd_end marks the last group issued so rcnt never runs past it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt   <= '0;
      rd_end <= 1'b0;
    end else if (state == LOAD && state_nx == READ) begin
      rcnt   <= '0;
      rd_end <= 1'b0;
    end else if (rd_load) begin
      if (rcnt == RLAST) rd_end <= 1'b1;
      else               rcnt   <= rcnt + aW'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_d1    <= '0;
      out_d2    <= '0;
      out_d3    <= '0;
      out_d4    <= '0;
    end else if (rd_load) begin
      out_valid <= 1'b1;
      out_last  <= (rcnt == RLAST);
      out_d1    <= ram_rd1;
      out_d2    <= ram_rd2;
      out_d3    <= ram_rd3;
      out_d4    <= ram_rd4;
    end else if (rd_take) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
